// File: rtl/csa_pkg.sv
// Shared constants for the pipelined carry-select adder/subtractor.
//   CSA_WIDTH  : default operand/result width
//   CSA_SEG_W  : default carry-select segment width
//   csa_mode_e : meaning of the 'sub' input (ADD=0, SUB=1)
package csa_pkg;

    localparam int CSA_WIDTH = 32;
    localparam int CSA_SEG_W = 8;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } csa_mode_e;

endpackage

// File: rtl/csa_seg_dual.sv
// One carry-select segment: both candidate sums are formed in parallel so
// the stage only has to pick one once its incoming carry is known.
//   a, b       : SEG_W-bit segment operands
//   sum0, c0   : sum and carry-out assuming carry-in 0
//   sum1, c1   : sum and carry-out assuming carry-in 1
module csa_seg_dual #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    output logic [SEG_W-1:0] sum0,
    output logic [SEG_W-1:0] sum1,
    output logic             c0,
    output logic             c1
);

    assign {c0, sum0} = {1'b0, a} + {1'b0, b};
    assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_csa_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready handshaking.
// Stage k resolves segment k using the carry registered by stage k-1; the
// not-yet-processed upper operand bits travel alongside in skew registers.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   out_valid / out_ready: result handshake (s, cout, ovf, zero)
//   sub                  : 0 -> a+b+cin, 1 -> a-b (cout=1 means no borrow)
module pipelined_csa_addsub
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SEG_W = CSA_SEG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEG = WIDTH / SEG_W;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;

    logic [NSEG-1:0]  v_r;
    logic [NSEG-1:0]  c_r;
    logic [WIDTH-1:0] s_r [NSEG];
    logic [WIDTH-1:0] a_r [NSEG-1];
    logic [WIDTH-1:0] b_r [NSEG-1];
    logic             ovf_r;
    logic             zero_r;

    logic [SEG_W-1:0] seg_a   [NSEG];
    logic [SEG_W-1:0] seg_b   [NSEG];
    logic [SEG_W-1:0] sum0    [NSEG];
    logic [SEG_W-1:0] sum1    [NSEG];
    logic [SEG_W-1:0] seg_sum [NSEG];
    logic [NSEG-1:0]  c0, c1, seg_cin, seg_cout;

    logic [WIDTH-1:0] s_nxt [NSEG];
    logic             ovf_nxt;

    assign advance  = !out_valid || out_ready;
    // Reset empties the pipe, so the block can always claim readiness then.
    assign in_ready = advance || reset;

    assign b_eff = (sub == MODE_SUB) ? ~b : b;
    assign c_in  = (sub == MODE_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg_a[k]   = a[SEG_W-1:0];
            assign seg_b[k]   = b_eff[SEG_W-1:0];
            assign seg_cin[k] = c_in;
        end else begin : g_rest
            assign seg_a[k]   = a_r[k-1][k*SEG_W +: SEG_W];
            assign seg_b[k]   = b_r[k-1][k*SEG_W +: SEG_W];
            assign seg_cin[k] = c_r[k-1];
        end

        csa_seg_dual #(.SEG_W(SEG_W)) u_seg (
            .a    (seg_a[k]),
            .b    (seg_b[k]),
            .sum0 (sum0[k]),
            .sum1 (sum1[k]),
            .c0   (c0[k]),
            .c1   (c1[k])
        );

        assign seg_sum[k]  = seg_cin[k] ? sum1[k] : sum0[k];
        assign seg_cout[k] = seg_cin[k] ? c1[k]   : c0[k];
    end

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            s_nxt[k] = (k == 0) ? '0 : s_r[k-1];
            s_nxt[k][k*SEG_W +: SEG_W] = seg_sum[k];
        end
        // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
        ovf_nxt = a_r[NSEG-2][WIDTH-1] ^ b_r[NSEG-2][WIDTH-1]
                ^ seg_sum[NSEG-1][SEG_W-1] ^ seg_cout[NSEG-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_r    <= '0;
            c_r    <= '0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                s_r[k] <= '0;
            end
            for (int k = 0; k < NSEG - 1; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
            end
        end else if (advance) begin
            v_r <= {v_r[NSEG-2:0], in_valid};
            for (int k = 0; k < NSEG - 1; k++) begin
                s_r[k] <= s_nxt[k];
                c_r[k] <= seg_cout[k];
            end
            a_r[0] <= a;
            b_r[0] <= b_eff;
            for (int k = 1; k < NSEG - 1; k++) begin
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
            end
            // Bubbles leave zeros at the output rather than stale junk.
            if (v_r[NSEG-2]) begin
                s_r[NSEG-1] <= s_nxt[NSEG-1];
                c_r[NSEG-1] <= seg_cout[NSEG-1];
                ovf_r       <= ovf_nxt;
                zero_r      <= (s_nxt[NSEG-1] == '0);
            end else begin
                s_r[NSEG-1] <= '0;
                c_r[NSEG-1] <= 1'b0;
                ovf_r       <= 1'b0;
                zero_r      <= 1'b0;
            end
        end
    end

    // Low bits of the final skew registers are already resolved upstream.
    logic unused_skew;
    assign unused_skew = ^{a_r[NSEG-2], b_r[NSEG-2]};

    assign out_valid = v_r[NSEG-1];
    assign s         = s_r[NSEG-1];
    assign cout      = c_r[NSEG-1];
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_pipelined_csa_addsub.sv
module tb_pipelined_csa_addsub;

    localparam int WIDTH = 32;
    localparam int SEG_W = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout, ovf, zero;

    int checks = 0;
    int errors = 0;

    pipelined_csa_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {s, cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
        longint ua, ub, sa, sy, cl, r_u, r_s;
        logic [31:0] res;
        logic co, ov;
        ua = x;
        ub = y;
        sa = longint'($signed(x));
        sy = longint'($signed(y));
        cl = ci;
        if (!sb) begin
            r_u = ua + ub + cl;
            r_s = sa + sy + cl;
            co  = (r_u > 64'sd4294967295);
        end else begin
            r_u = ua - ub;
            r_s = sa - sy;
            co  = (ua >= ub);
        end
        res = r_u[31:0];
        ov  = (r_s > 64'sd2147483647) || (r_s < -64'sd2147483648);
        return {res, co, ov, (res == 32'h0)};
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // Entered at a falling edge; presents one op and measures its latency.
    task automatic run_single(input string tag, input logic [31:0] x, input logic [31:0] y,
                              input logic ci, input logic sb, input logic [34:0] exp);
        int n;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cin       = ci;
        sub       = sb;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        @(negedge clock);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = $urandom_range(0, 1);
        n        = 1;
        #1;
        while (!out_valid && n < 10) begin
            @(negedge clock);
            n++;
            #1;
        end
        check({tag, "_latency"}, 64'(n), 64'(4));
        check(tag, 64'({s, cout, ovf, zero}), 64'(exp));
        @(negedge clock);
    endtask

    logic [34:0] exp_q[$];
    logic [34:0] held;
    logic [34:0] exp_v;
    int issued, got, stale, accepted, cyc;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({s, cout, ovf, zero}), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("first_in_ready", 64'(in_ready), 64'(1));
        @(negedge clock);
        check("idle_outputs", 64'({out_valid, s, cout, ovf, zero}), 64'(0));

        // Directed boundary cases
        run_single("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h0, 1'b1, 1'b0, 1'b1});
        run_single("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        run_single("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, {32'h2, 1'b1, 1'b0, 1'b0});
        run_single("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        run_single("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        run_single("add_cin", 32'h0000_00FF, 32'h0, 1'b1, 1'b0, {32'h0000_0100, 1'b0, 1'b0, 1'b0});

        // Back-to-back adds with a 3-cycle output stall
        issued = 0;
        got    = 0;
        held   = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            in_valid  = (issued < 8);
            a         = 32'(issued);
            b         = 32'(issued) * 32'h0101_0101;
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = !(c >= 5 && c <= 7);
            #1;
            if (c >= 5 && c <= 7) begin
                check("stall_in_ready", 64'(in_ready), 64'(0));
                check("stall_out_valid", 64'(out_valid), 64'(1));
                if (c == 5) held = {s, cout, ovf, zero};
                else check("stall_hold", 64'({s, cout, ovf, zero}), 64'(held));
            end
            if (out_valid && out_ready) begin
                exp_v = {32'(got) * 32'h0101_0102, 1'b0, 1'b0, (got == 0)};
                check("b2b_result", 64'({s, cout, ovf, zero}), 64'(exp_v));
                got++;
            end
            if (in_valid && in_ready) issued++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(got), 64'(8));

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            sub      = $urandom_range(0, 1);
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clock);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        reset = 1'b0;
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'(1));
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) stale++;
            @(negedge clock);
        end
        check("no_stale", 64'(stale), 64'(0));
        run_single("post_rst_op", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
                   {32'h2345_678A, 1'b0, 1'b0, 1'b0});

        // Random traffic against the reference model
        accepted = 0;
        cyc      = 0;
        while ((accepted < 10000 || exp_q.size() != 0) && cyc < 80000) begin
            in_valid  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
            a         = rand_operand();
            b         = rand_operand();
            cin       = $urandom_range(0, 1);
            sub       = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra_result", 64'(1), 64'(0));
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rnd_result", 64'({s, cout, ovf, zero}), 64'(exp_v));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                accepted++;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        check("rnd_drain", 64'(exp_q.size()), 64'(0));
        check("rnd_accepted", 64'(accepted), 64'(10000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_csa_addsub.md
PIPELINED_CSA_ADDSUB -- requirements
Module: pipelined_csa_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter SEG_W, default 8: carry-select segment width; WIDTH divisible by SEG_W, NSEG = WIDTH/SEG_W >= 2.
REQ-003 SHALL have port clock  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands.
REQ-008 SHALL have port cin  input  1  carry-in; add mode only.
REQ-009 SHALL have port sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port s  output  WIDTH  sum/difference.
REQ-013 SHALL have port cout  output  1  carry-out; in sub mode 1 = no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-015 SHALL have port zero  output  1  s equals 0.

Function
REQ-016 SHALL accept an operation only when in_valid and in_ready are both 1 on a clock edge.
REQ-017 SHALL define advance = !out_valid | out_ready; in_ready SHALL equal advance, combinationally.
REQ-018 SHALL hold every pipeline register, including valid bits, when advance is 0.
REQ-019 SHALL implement NSEG register stages; stage k resolves segment k (bits k*SEG_W upward) from the carry registered by stage k-1.
REQ-020 SHALL compute, per segment, both candidate sums (carry-in 0 and 1) and select by the incoming carry.
REQ-021 SHALL carry unprocessed upper operand bits forward in skew registers alongside completed low result bits.
REQ-022 SHALL, in sub mode, use operand ~b and force carry-in to 1, ignoring cin.
REQ-023 SHALL present out_valid exactly NSEG cycles after acceptance when out_ready is held 1.
REQ-024 SHALL sustain one accepted operation per cycle with no bubbles while out_ready is 1.
REQ-025 SHALL preserve result order; no operation SHALL be dropped or duplicated under any out_ready pattern.
REQ-026 SHALL set ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-027 SHALL set zero = 1 exactly when all WIDTH bits of s are 0.
REQ-028 SHALL hold s, cout, ovf, zero and out_valid stable while out_valid=1 and out_ready=0.
REQ-029 SHALL treat a cycle with in_valid=0 and advance=1 as a bubble (stage valid 0), not a result.
REQ-030 SHALL, when the last stage is full and out_ready=1, accept a new input in the same cycle.

Reset
REQ-031 SHALL clear all stage valid bits and out_valid to 0 on the edge where reset=1.
REQ-032 SHALL drive s=0, cout=0, ovf=0, zero=0 after reset until the first result.
REQ-033 SHALL discard all in-flight operations when reset asserts mid-stream; none SHALL appear afterwards.
REQ-034 SHALL drive in_ready=1 while reset is 1 and on the first cycle after reset deasserts; no operation is accepted on a reset edge.

Structure
REQ-035 SHALL place shared constants (default WIDTH, SEG_W, mode encodings ADD=0, SUB=1) in package csa_pkg.
REQ-036 SHALL use one combinational sub-module csa_seg_dual (SEG_W-bit inputs; sum0, sum1, c0, c1 outputs), instantiated NSEG times via generate.
REQ-037 SHALL contain no latches and no combinational path from in_valid to out_valid.

Verification (WIDTH=32, SEG_W=8, latency 4)
REQ-038 SHALL check add 0xFFFFFFFF+0x00000001, cin=0 -> 4 cycles later s=0x00000000, cout=1, ovf=0, zero=1.
REQ-039 SHALL check sub 5-7 -> s=0xFFFFFFFE, cout=0, ovf=0, zero=0; sub 7-5 -> s=0x2, cout=1.
REQ-040 SHALL check add 0x7FFFFFFF+1 -> s=0x80000000, ovf=1, cout=0; sub 0x80000000-1 -> s=0x7FFFFFFF, ovf=1.
REQ-041 SHALL check 8 back-to-back adds (i+i*0x01010101) with out_ready=0 for 3 cycles mid-stream -> all 8 results in order, in_ready=0 while stalled with full pipeline, outputs stable.
REQ-042 SHALL check reset asserted with 3 operations in flight -> out_valid=0 next cycle, no stale result afterwards, next accepted op returns after 4 cycles.
REQ-043 SHALL compare 10,000 random ops with random in_valid/out_ready against a reference model.
